// File: rtl/m_sequence_phase_decoder.sv
// 63-chip M-sequence phase decoder: buffers one frame, correlates it
// serially against all 63 cyclic shifts, reports the best shift.
// Ports: clkin/rstn (sync, active-low); in_valid/in_bit/in_ready chip
//   input handshake; code_out/metric/lock result, code_valid 1-cycle pulse.
module m_sequence_phase_decoder #(
   parameter logic [5:0] POLYNOME = 6'b100111,
   parameter logic [5:0] PHASE    = 6'b101010,
   parameter int         N        = 63,
   parameter int         LENGHT   = 6,
   parameter logic [5:0] THRESH   = 6'd48
) (
   input  logic              clkin,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              in_ready,
   output logic [LENGHT-1:0] code_out,
   output logic [LENGHT-1:0] metric,
   output logic              code_valid,
   output logic              lock
);

   localparam logic [LENGHT-1:0] LAST = LENGHT'(N - 1);
   localparam logic [LENGHT-1:0] ZERO = '0;

   typedef enum logic [1:0] {
      S_COLLECT,
      S_CORR,
      S_RESULT
   } state_t;

   state_t state_q, state_d;

   logic [N-1:0]      chip_buf_q, chip_buf_d;
   logic [LENGHT-1:0] wr_idx_q, wr_idx_d;
   logic [LENGHT-1:0] k_q, k_d;
   logic [LENGHT-1:0] j_q, j_d;
   logic [LENGHT-1:0] lfsr_q, lfsr_d;
   logic [LENGHT-1:0] cand_q, cand_d;
   logic [LENGHT-1:0] acc_q, acc_d;
   logic [LENGHT-1:0] best_q, best_d;
   logic [LENGHT-1:0] best_k_q, best_k_d;
   logic [LENGHT-1:0] code_q, code_d;
   logic [LENGHT-1:0] metric_q, metric_d;
   logic              lock_q, lock_d;
   logic              code_valid_q, code_valid_d;

   logic              s_local;
   logic              match;
   logic [LENGHT-1:0] acc_new;
   logic              last_chip;
   logic              last_cand;

   function automatic logic [LENGHT-1:0] lfsr_step(
      input logic [LENGHT-1:0] st
   );
      return {^(POLYNOME & st), st[LENGHT-1:1]};
   endfunction

   // acc_new tops out at 63 on the final chip, so 6 bits suffice
   assign s_local   = ^(POLYNOME & lfsr_q);
   assign match     = (chip_buf_q[j_q] == s_local);
   assign acc_new   = acc_q + {{(LENGHT-1){1'b0}}, match};
   assign last_chip = (j_q == LAST);
   assign last_cand = (k_q == LAST);

   // State register
   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state_q <= S_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_COLLECT: begin
            if (in_valid && (wr_idx_q == LAST)) state_d = S_CORR;
         end
         S_CORR: begin
            if (last_chip && last_cand) state_d = S_RESULT;
         end
         S_RESULT: state_d = S_COLLECT;
         default:  state_d = S_COLLECT;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_COLLECT: in_ready = 1'b1;
         default:   in_ready = 1'b0;
      endcase
   end

   // Datapath next-state
   always_comb begin
      chip_buf_d   = chip_buf_q;
      wr_idx_d     = wr_idx_q;
      k_d          = k_q;
      j_d          = j_q;
      lfsr_d       = lfsr_q;
      cand_d       = cand_q;
      acc_d        = acc_q;
      best_d       = best_q;
      best_k_d     = best_k_q;
      code_d       = code_q;
      metric_d     = metric_q;
      lock_d       = lock_q;
      code_valid_d = 1'b0;
      unique case (state_q)
         S_COLLECT: begin
            // Correlator is primed for candidate 0 while collecting
            k_d    = ZERO;
            j_d    = ZERO;
            acc_d  = ZERO;
            lfsr_d = PHASE;
            cand_d = PHASE;
            if (in_valid) begin
               chip_buf_d[wr_idx_q] = in_bit;
               wr_idx_d = (wr_idx_q == LAST) ? ZERO : wr_idx_q + 1'b1;
            end
         end
         S_CORR: begin
            if (last_chip) begin
               // Strict '>' keeps the lowest shift on ties
               if ((k_q == ZERO) || (acc_new > best_q)) begin
                  best_d   = acc_new;
                  best_k_d = k_q;
               end
               k_d    = k_q + 1'b1;
               j_d    = ZERO;
               acc_d  = ZERO;
               cand_d = lfsr_step(cand_q);
               lfsr_d = lfsr_step(cand_q);
            end else begin
               j_d    = j_q + 1'b1;
               acc_d  = acc_new;
               lfsr_d = lfsr_step(lfsr_q);
            end
         end
         S_RESULT: begin
            code_d       = best_k_q;
            metric_d     = best_q;
            lock_d       = (best_q >= THRESH);
            code_valid_d = 1'b1;
            wr_idx_d     = ZERO;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         chip_buf_q   <= '0;
         wr_idx_q     <= '0;
         k_q          <= '0;
         j_q          <= '0;
         lfsr_q       <= PHASE;
         cand_q       <= PHASE;
         acc_q        <= '0;
         best_q       <= '0;
         best_k_q     <= '0;
         code_q       <= '0;
         metric_q     <= '0;
         lock_q       <= 1'b0;
         code_valid_q <= 1'b0;
      end else begin
         chip_buf_q   <= chip_buf_d;
         wr_idx_q     <= wr_idx_d;
         k_q          <= k_d;
         j_q          <= j_d;
         lfsr_q       <= lfsr_d;
         cand_q       <= cand_d;
         acc_q        <= acc_d;
         best_q       <= best_d;
         best_k_q     <= best_k_d;
         code_q       <= code_d;
         metric_q     <= metric_d;
         lock_q       <= lock_d;
         code_valid_q <= code_valid_d;
      end
   end

   assign code_out   = code_q;
   assign metric     = metric_q;
   assign lock       = lock_q;
   assign code_valid = code_valid_q;

endmodule

// File: tb/tb_m_sequence_phase_decoder.sv
// Bench for m_sequence_phase_decoder: table of frames plus
// hand-written sequences for CORR-time input and mid-CORR reset.
module tb_m_sequence_phase_decoder;

   logic       clkin = 1'b0;
   logic       rstn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_ready;
   logic [5:0] code_out;
   logic [5:0] metric;
   logic       code_valid;
   logic       lock;

   int checks = 0;
   int errors = 0;

   bit seq [63];

   typedef struct {
      int kind;
      int code;
      bit gaps;
      int exp_code;
      int exp_metric;
      bit exp_lock;
   } vec_t;

   vec_t vecs [5];

   m_sequence_phase_decoder dut (
      .clkin      (clkin),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_ready   (in_ready),
      .code_out   (code_out),
      .metric     (metric),
      .code_valid (code_valid),
      .lock       (lock)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic gen_seq();
      logic [5:0] st;
      logic [5:0] poly;
      poly = 6'b100111;
      st = 6'b101010;
      for (int j = 0; j < 63; j++) begin
         seq[j] = ^(poly & st);
         st = {seq[j], st[5:1]};
      end
   endtask

   // kind 0 clean, 1 every 7th chip inverted, 2 all zero, 3 all one
   function automatic bit chip(input int kind, input int code, input int i);
      bit b;
      b = seq[(i + code) % 63];
      case (kind)
         1:       return b ^ ((i % 7) == 0);
         2:       return 1'b0;
         3:       return 1'b1;
         default: return b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic send_frame(input int kind, input int code, input bit gaps);
      for (int i = 0; i < 63; i++) begin
         if (gaps) begin
            int idle;
            idle = $urandom_range(0, 3);
            in_valid = 1'b0;
            for (int g = 0; g < idle; g++) tick();
         end
         if (!in_ready) check("ready_collect", in_ready, 1);
         in_valid = 1'b1;
         in_bit = chip(kind, code, i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Counts cycles from the last accepted chip until code_valid
   task automatic wait_result(input bit hold_valid, output int lat);
      int bad_ready;
      bad_ready = 0;
      lat = 0;
      in_valid = hold_valid;
      while (!code_valid && lat < 5000) begin
         if (in_ready) bad_ready++;
         in_bit = $urandom_range(0, 1);
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check("ready_low_in_corr", bad_ready, 0);
      if (!code_valid) check("result_timeout", 0, 1);
   endtask

   task automatic check_result(input string tag, input int ec,
                               input int em, input bit el);
      check({tag, "_code"}, int'(code_out), ec);
      check({tag, "_metric"}, int'(metric), em);
      check({tag, "_lock"}, int'(lock), int'(el));
   endtask

   initial begin
      int lat;
      int pulses;

      vecs[0] = '{kind: 0, code: 0,  gaps: 0, exp_code: 0,
                  exp_metric: 63, exp_lock: 1};
      vecs[1] = '{kind: 0, code: 37, gaps: 1, exp_code: 37,
                  exp_metric: 63, exp_lock: 1};
      vecs[2] = '{kind: 1, code: 5,  gaps: 0, exp_code: 5,
                  exp_metric: 54, exp_lock: 1};
      vecs[3] = '{kind: 2, code: 0,  gaps: 0, exp_code: 0,
                  exp_metric: 31, exp_lock: 0};
      vecs[4] = '{kind: 3, code: 0,  gaps: 1, exp_code: 0,
                  exp_metric: 32, exp_lock: 0};

      gen_seq();

      repeat (3) tick();
      rstn = 1'b1;
      tick();
      check("rst_code", int'(code_out), 0);
      check("rst_metric", int'(metric), 0);
      check("rst_valid", int'(code_valid), 0);
      check("rst_lock", int'(lock), 0);
      check("rst_ready", int'(in_ready), 1);

      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].kind, vecs[v].code, vecs[v].gaps);
         wait_result(1'b0, lat);
         check($sformatf("v%0d_latency", v), lat, 3970);
         check_result($sformatf("v%0d", v), vecs[v].exp_code,
                      vecs[v].exp_metric, vecs[v].exp_lock);
         tick();
         check($sformatf("v%0d_pulse_end", v), int'(code_valid), 0);
         check($sformatf("v%0d_ready_back", v), int'(in_ready), 1);
         check($sformatf("v%0d_hold_code", v), int'(code_out),
               vecs[v].exp_code);
      end

      // in_valid held high with junk chips through CORR
      send_frame(0, 17, 1'b0);
      wait_result(1'b1, lat);
      check("hold_latency", lat, 3970);
      check_result("hold17", 17, 63, 1'b1);
      tick();
      send_frame(0, 62, 1'b0);
      wait_result(1'b0, lat);
      check_result("c62", 62, 63, 1'b1);
      tick();

      // Reset partway through CORR
      send_frame(0, 20, 1'b0);
      pulses = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (code_valid) pulses++;
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("mid_rst_code", int'(code_out), 0);
      check("mid_rst_metric", int'(metric), 0);
      check("mid_rst_lock", int'(lock), 0);
      check("mid_rst_ready", int'(in_ready), 1);
      for (int c = 0; c < 4000; c++) begin
         tick();
         if (code_valid) pulses++;
      end
      check("mid_rst_no_pulse", pulses, 0);
      send_frame(0, 12, 1'b1);
      wait_result(1'b0, lat);
      check("after_rst_latency", lat, 3970);
      check_result("c12", 12, 63, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
